// File: rtl/counter_pkg.sv
// Shared constants for the sequential counter library.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/up_mod_counter_if.sv
// Control/status bundle of one up_mod_counter stage.
interface up_mod_counter_if #(
    parameter int WIDTH = counter_pkg::COUNTER_WIDTH_DEFAULT
);
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             sat_mode;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             carry;
    logic             ovf;

    modport master (
        output en, clr, load, load_val, limit, sat_mode, ovf_clr,
        input  count, tc, carry, ovf
    );

    modport slave (
        input  en, clr, load, load_val, limit, sat_mode, ovf_clr,
        output count, tc, carry, ovf
    );
endinterface

// File: rtl/up_mod_counter.sv
// Loadable modulo up counter with wrap/saturate mode, cascade carry and sticky overflow.
module up_mod_counter
    import counter_pkg::*;
#(
    parameter int             WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    up_mod_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             at_term;

    // ">=" rather than "==" so a load above limit or a lowered limit still terminates.
    assign at_term   = (count_q >= bus.limit);
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = at_term;
    assign bus.carry = bus.en & at_term & (bus.sat_mode == MODE_WRAP) & ~bus.clr & ~bus.load;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~bus.ovf_clr;
        if (bus.clr) begin
            count_d = RESET_VAL;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.en) begin
            if (!at_term) begin
                count_d = count_q + 1'b1;
            end else if (bus.sat_mode == MODE_SAT) begin
                count_d = bus.limit;
                ovf_d   = 1'b1;
            end else begin
                count_d = '0;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= RESET_VAL;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/up_mod_counter.md
Name: up_mod_counter

Overview:
- Loadable, modulo-programmable up counter. It is the up-counting counterpart of the team's free-running 4-bit down counter.
- Counts up from 0 to a runtime limit, then wraps to 0 or saturates at the limit.
- Provides a carry pulse for cascading stages and a sticky overflow flag for status registers.
- Used as a timer/prescaler stage in the sequential counter library.

Parameters:
- WIDTH, 4, counter width in bits.
- RESET_VAL, 0, value loaded into count on reset and on clr; must be < 2**WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk only.
- en  in  1  count enable; increment occurs only on cycles where en=1.
- clr  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value written by load.
- limit  in  WIDTH  terminal value; the count sequence is 0..limit.
- sat_mode  in  1  0 = wrap to 0 after limit; 1 = hold at limit.
- ovf_clr  in  1  clears the sticky overflow flag.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count, combinational: (count >= limit).
- carry  out  1  combinational cascade pulse: en & tc & ~sat_mode & ~clr & ~load; feeds the next stage's en.
- ovf  out  1  sticky overflow flag (registered).

Behaviour:
- All state updates occur on the rising edge of clk; there is no asynchronous path.
- Per-edge priority: rst=0 > clr > load > en > hold.
- Reset (rst=0): count=RESET_VAL, ovf=0. tc and carry follow combinationally from the reset count.
- clr=1: count=RESET_VAL, ovf=0. en and load are ignored that cycle.
- load=1 (clr=0): count=load_val, exactly as given, even when load_val > limit. ovf is unchanged. en is ignored that cycle.
- en=1 with count < limit: count = count+1. Latency is 1 cycle; the new value is visible after the edge.
- en=1 with count >= limit and sat_mode=0 (wrap):
  - count=0 and ovf is set.
  - carry is high during the cycle preceding this edge.
- en=1 with count >= limit and sat_mode=1 (saturate):
  - count=limit; an out-of-range value is clamped to limit.
  - ovf is set; carry stays 0.
- en=0: count holds; ovf holds except as cleared by ovf_clr.
- Arithmetic:
  - Unsigned, WIDTH bits; the increment never overflows the register because the wrap check precedes it.
  - limit = 2**WIDTH-1 gives full natural range.
  - limit = 0:
    - wrap mode: count stays 0, with carry and ovf firing on every enabled cycle.
    - sat mode: count holds 0 and ovf sets on the first enabled cycle.
- ovf_clr:
  - Clears ovf on the edge.
  - If an overflow event (wrap or saturate) occurs on the same edge, set wins and ovf=1.
- limit changes are used immediately (no shadowing). If limit drops below the current count, the next enabled edge takes the >= branch.
- sat_mode changes take effect on the next edge.
- Reset mid-count: the next edge with rst=0 forces RESET_VAL regardless of en/load/clr.
- The block holds no other state and has no FSM beyond the count and ovf registers.

Decomposition:
- Shared package counter_pkg:
  - COUNTER_WIDTH_DEFAULT (4).
  - Mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1, which benches and integrators use to drive sat_mode.
- No sub-module. The comparator/next-state logic and the two registers stay flat in up_mod_counter.
- Cascading is done at integration by chaining carry to the next instance's en.

Test Plan:
- Reset/basic count (WIDTH=4, limit=15, sat_mode=0):
  - Stimulus: hold rst=0 for 2 edges, release, en=1 for 17 cycles.
  - Response: count 0 during reset, then 1,2,...,15,0,1; carry high only while count=15; ovf=1 after the wrap.
- Modulo-10 wrap (limit=9, en=1):
  - Response: count 0..9,0..9; tc high at 9; carry high at 9; ovf set at the first 9->0.
  - Then pulse ovf_clr=1 at count=4: ovf=0 until the next 9->0.
- Saturate (limit=5, sat_mode=1, en=1 from 0 for 8 cycles):
  - Response: count 1..5, then holds 5; carry always 0; ovf=1 from the edge that would have passed 5.
- Priority (count=3, limit=15):
  - Assert load=1, load_val=12 with en=1: count=12.
  - Next cycle assert clr=1 and load=1 together: count=RESET_VAL(0), ovf=0.
  - Assert rst=0 with clr=0, load=1: count=0.
- Out-of-range load (limit=7, load_val=12, then en=1 for one cycle):
  - sat_mode=0: count 12 -> 0, ovf=1.
  - Repeat with sat_mode=1: count 12 -> 7, ovf=1.
- ovf set/clear collision (limit=3, count=3, en=1, ovf_clr=1 on the same edge):
  - Response: count=0, ovf=1 (set wins); next cycle ovf_clr=1 with en=0 gives ovf=0.
